// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, funct codes, ALU op codes and the
// 12-bit control word layout used by the ID stage.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ADDI   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_JALR = 3'b000;
   localparam logic [2:0] F3_LD   = 3'b011;
   localparam logic [2:0] F3_SD   = 3'b011;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLL = 3'b100,
      ALU_SLT = 3'b101
   } alu_op_e;

   typedef struct packed {
      logic    branch;
      logic    jal;
      logic    jalr;
      logic    reg_wr;
      logic    link;
      logic    mem_to_reg;
      logic    mem_rd;
      logic    mem_wr;
      alu_op_e alu_op;
      logic    alu_src;
   } ctrl_t;

   localparam logic [11:0] CTRL_NONE   = 12'b000_000_00_0000;
   localparam logic [11:0] CTRL_ADDI   = 12'b000_100_00_0001;
   localparam logic [11:0] CTRL_LD     = 12'b000_101_10_0001;
   localparam logic [11:0] CTRL_SD     = 12'b000_000_01_0001;
   localparam logic [11:0] CTRL_JALR   = 12'b001_110_00_0000;
   localparam logic [11:0] CTRL_JAL    = 12'b010_110_00_0000;
   localparam logic [11:0] CTRL_BRANCH = 12'b100_000_00_0000;
   localparam logic [11:0] CTRL_ADD    = 12'b000_100_00_0000;
   localparam logic [11:0] CTRL_SUB    = 12'b000_100_00_0010;
   localparam logic [11:0] CTRL_AND    = 12'b000_100_00_0100;
   localparam logic [11:0] CTRL_OR     = 12'b000_100_00_0110;
   localparam logic [11:0] CTRL_SLL    = 12'b000_100_00_1000;
   localparam logic [11:0] CTRL_SLT    = 12'b000_100_00_1010;

   function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
      return {{(XLEN-12){v[11]}}, v};
   endfunction

endpackage

// File: rtl/id_control.sv
// Main decoder: opcode/funct fields to the 12-bit control word.
// Anything not recognised decodes to CTRL_NONE, which acts as a bubble.
module id_control
   import riscv_pkg::*;
(
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   output logic [11:0] ctrl_word
);

   always_comb begin
      ctrl_word = CTRL_NONE;
      case (opcode)
         OP_RTYPE: begin
            if (funct7 == F7_BASE) begin
               case (funct3)
                  F3_ADD:  ctrl_word = CTRL_ADD;
                  F3_SLL:  ctrl_word = CTRL_SLL;
                  F3_SLT:  ctrl_word = CTRL_SLT;
                  F3_OR:   ctrl_word = CTRL_OR;
                  F3_AND:  ctrl_word = CTRL_AND;
                  default: ctrl_word = CTRL_NONE;
               endcase
            end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
               ctrl_word = CTRL_SUB;
            end
         end
         OP_ADDI:  if (funct3 == F3_ADDI) ctrl_word = CTRL_ADDI;
         OP_LOAD:  if (funct3 == F3_LD)   ctrl_word = CTRL_LD;
         OP_STORE: if (funct3 == F3_SD)   ctrl_word = CTRL_SD;
         OP_JALR:  if (funct3 == F3_JALR) ctrl_word = CTRL_JALR;
         OP_JAL:   ctrl_word = CTRL_JAL;
         OP_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE || funct3 == F3_BLT || funct3 == F3_BGE)
               ctrl_word = CTRL_BRANCH;
         end
         default:  ctrl_word = CTRL_NONE;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32 instruction-decode stage: decode, immediate generation, branch/jump
// resolution with IF redirect, ID/EX registers and WB write pass-through.
module id_stage
   import riscv_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             op_write,
   input  logic [XLEN-1:0]  pipe_pc4,
   input  logic [XLEN-1:0]  pipe_pc,
   input  logic [XLEN-1:0]  pipe_data,
   input  logic [XLEN-1:0]  write_data,
   input  logic [XLEN-1:0]  write_addr,
   input  logic [XLEN-1:0]  load_pc_reg_value1,
   input  logic [XLEN-1:0]  load_pc_reg_value2,
   output logic             control_j,
   output logic [XLEN-1:0]  pc_j,
   output logic [8:0]       ctrl_ex,
   output logic [XLEN-1:0]  pc4_ex,
   output logic [XLEN-1:0]  r_data1,
   output logic [XLEN-1:0]  r_data2,
   output logic [XLEN-1:0]  extended,
   output logic [XLEN-1:0]  rd_ex,
   output logic [XLEN-1:0]  load_pc_reg_addr1,
   output logic [XLEN-1:0]  load_pc_reg_addr2,
   output logic [XLEN-1:0]  write_pc_reg_value,
   output logic [XLEN-1:0]  write_pc_reg_addr
);

   logic [11:0]     ctrl_word;
   ctrl_t           ctrl;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm;
   logic            br_taken;
   logic            unused_wr_addr_hi;

   assign opcode = pipe_data[6:0];
   assign funct3 = pipe_data[14:12];

   id_control u_id_control (
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7    (pipe_data[31:25]),
      .ctrl_word (ctrl_word)
   );

   assign ctrl = ctrl_t'(ctrl_word);

   assign load_pc_reg_addr1 = {27'b0, pipe_data[19:15]};
   assign load_pc_reg_addr2 = {27'b0, pipe_data[24:20]};

   always_comb begin
      imm = '0;
      case (opcode)
         OP_ADDI, OP_LOAD, OP_JALR: imm = sext12(pipe_data[31:20]);
         OP_STORE:  imm = sext12({pipe_data[31:25], pipe_data[11:7]});
         OP_BRANCH: imm = {{20{pipe_data[31]}}, pipe_data[7], pipe_data[30:25],
                           pipe_data[11:8], 1'b0};
         OP_JAL:    imm = {{12{pipe_data[31]}}, pipe_data[19:12], pipe_data[20],
                           pipe_data[30:21], 1'b0};
         default:   imm = '0;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         F3_BEQ:  br_taken = (load_pc_reg_value1 == load_pc_reg_value2);
         F3_BNE:  br_taken = (load_pc_reg_value1 != load_pc_reg_value2);
         F3_BLT:  br_taken = ($signed(load_pc_reg_value1) <  $signed(load_pc_reg_value2));
         F3_BGE:  br_taken = ($signed(load_pc_reg_value1) >= $signed(load_pc_reg_value2));
         default: br_taken = 1'b0;
      endcase
   end

   // Redirect is held off while reset is asserted so IF never sees a stray jump.
   always_comb begin
      control_j = 1'b0;
      pc_j      = '0;
      if (reset_n) begin
         if (ctrl.jal) begin
            control_j = 1'b1;
            pc_j      = pipe_pc + imm;
         end else if (ctrl.jalr) begin
            control_j = 1'b1;
            pc_j      = (load_pc_reg_value1 + imm) & ~32'd1;
         end else if (ctrl.branch && br_taken) begin
            control_j = 1'b1;
            pc_j      = pipe_pc + imm;
         end
      end
   end

   always_comb begin
      write_pc_reg_addr  = '0;
      write_pc_reg_value = '0;
      if (op_write && write_addr[4:0] != 5'd0) begin
         write_pc_reg_addr  = {27'b0, write_addr[4:0]};
         write_pc_reg_value = write_data;
      end
   end

   assign unused_wr_addr_hi = ^write_addr[31:5];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_ex  <= '0;
         pc4_ex   <= '0;
         r_data1  <= '0;
         r_data2  <= '0;
         extended <= '0;
         rd_ex    <= '0;
      end else begin
         ctrl_ex  <= ctrl[8:0];
         pc4_ex   <= pipe_pc4;
         r_data1  <= load_pc_reg_value1;
         r_data2  <= load_pc_reg_value2;
         extended <= imm;
         rd_ex    <= ctrl.reg_wr ? {27'b0, pipe_data[11:7]} : '0;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: the driver queues hand-computed expectations,
// the monitor checks combinational outputs mid-cycle and ID/EX outputs one cycle later.
module tb_id_stage;

   logic        clk;
   logic        reset_n;
   logic        op_write;
   logic [31:0] pipe_pc4, pipe_pc, pipe_data, write_data, write_addr;
   logic [31:0] load_pc_reg_value1, load_pc_reg_value2;
   logic        control_j;
   logic [31:0] pc_j;
   logic [8:0]  ctrl_ex;
   logic [31:0] pc4_ex, r_data1, r_data2, extended, rd_ex;
   logic [31:0] load_pc_reg_addr1, load_pc_reg_addr2;
   logic [31:0] write_pc_reg_value, write_pc_reg_addr;

   id_stage dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .op_write           (op_write),
      .pipe_pc4           (pipe_pc4),
      .pipe_pc            (pipe_pc),
      .pipe_data          (pipe_data),
      .write_data         (write_data),
      .write_addr         (write_addr),
      .load_pc_reg_value1 (load_pc_reg_value1),
      .load_pc_reg_value2 (load_pc_reg_value2),
      .control_j          (control_j),
      .pc_j               (pc_j),
      .ctrl_ex            (ctrl_ex),
      .pc4_ex             (pc4_ex),
      .r_data1            (r_data1),
      .r_data2            (r_data2),
      .extended           (extended),
      .rd_ex              (rd_ex),
      .load_pc_reg_addr1  (load_pc_reg_addr1),
      .load_pc_reg_addr2  (load_pc_reg_addr2),
      .write_pc_reg_value (write_pc_reg_value),
      .write_pc_reg_addr  (write_pc_reg_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] addr1, addr2;
      logic        cj;
      logic [31:0] pcj, wa, wv;
      logic [8:0]  ctrl;
      logic [31:0] pc4, rd1, rd2, ext, rd;
   } exp_t;

   exp_t q_comb[$];
   exp_t q_reg[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input string name, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic opw, input logic [31:0] wa_in, input logic [31:0] wd_in,
                        input logic cj, input logic [31:0] pcj, input logic [8:0] ctrl,
                        input logic [31:0] ext, input logic [31:0] rd,
                        input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] wa, input logic [31:0] wv);
      exp_t e;
      @(posedge clk);
      #1;
      pipe_data = inst; pipe_pc = pc; pipe_pc4 = pc + 32'd4;
      load_pc_reg_value1 = v1; load_pc_reg_value2 = v2;
      op_write = opw; write_addr = wa_in; write_data = wd_in;
      e.name = name; e.addr1 = a1; e.addr2 = a2; e.cj = cj; e.pcj = pcj;
      e.wa = wa; e.wv = wv; e.ctrl = ctrl; e.pc4 = pc + 32'd4;
      e.rd1 = v1; e.rd2 = v2; e.ext = ext; e.rd = rd;
      q_comb.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && (q_comb.size() + q_reg.size()) != 0; i++) @(posedge clk);
      @(negedge clk);
      check("queue_drain", q_comb.size() + q_reg.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q_reg.size() != 0) begin
         e = q_reg.pop_front();
         check({e.name, ".ctrl_ex"},  {23'b0, ctrl_ex}, {23'b0, e.ctrl});
         check({e.name, ".pc4_ex"},   pc4_ex,   e.pc4);
         check({e.name, ".r_data1"},  r_data1,  e.rd1);
         check({e.name, ".r_data2"},  r_data2,  e.rd2);
         check({e.name, ".extended"}, extended, e.ext);
         check({e.name, ".rd_ex"},    rd_ex,    e.rd);
      end
      if (q_comb.size() != 0) begin
         e = q_comb.pop_front();
         check({e.name, ".addr1"},     load_pc_reg_addr1,  e.addr1);
         check({e.name, ".addr2"},     load_pc_reg_addr2,  e.addr2);
         check({e.name, ".control_j"}, {31'b0, control_j}, {31'b0, e.cj});
         check({e.name, ".pc_j"},      pc_j,               e.pcj);
         check({e.name, ".wr_addr"},   write_pc_reg_addr,  e.wa);
         check({e.name, ".wr_value"},  write_pc_reg_value, e.wv);
         q_reg.push_back(e);
      end
   end

   initial begin
      reset_n = 1'b0; op_write = 1'b0;
      pipe_pc4 = '0; pipe_pc = '0; pipe_data = '0; write_data = '0; write_addr = '0;
      load_pc_reg_value1 = '0; load_pc_reg_value2 = '0;
      #3;
      check("rst.ctrl_ex",   {23'b0, ctrl_ex}, 32'd0);
      check("rst.pc4_ex",    pc4_ex,   32'd0);
      check("rst.extended",  extended, 32'd0);
      check("rst.rd_ex",     rd_ex,    32'd0);
      check("rst.control_j", {31'b0, control_j}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      //     name        inst          pc    v1           v2           opw wa_in         wd_in         cj pcj   ctrl          ext           rd  a1  a2  wa  wv
      issue("addi",     32'h007A0613, 400,  8,           33,          1, 12,           15,           0, 0,    9'b100000001, 7,            12, 20, 7,  12, 15);
      issue("beq_t",    32'h00208863, 100,  5,           5,           1, 0,            99,           1, 116,  9'b000000000, 16,           0,  1,  2,  0,  0);
      issue("beq_nt",   32'h00208863, 100,  5,           6,           0, 5,            7,            0, 0,    9'b000000000, 16,           0,  1,  2,  0,  0);
      issue("bne_t",    32'h00209863, 100,  5,           6,           1, 32'hFFFFFFEC, 32'hDEADBEEF, 1, 116,  9'b000000000, 16,           0,  1,  2,  12, 32'hDEADBEEF);
      issue("blt_t",    32'h0020C863, 100,  32'hFFFFFFFF, 1,          0, 0,            0,            1, 116,  9'b000000000, 16,           0,  1,  2,  0,  0);
      issue("bge_nt",   32'h0020D863, 100,  32'hFFFFFFFF, 1,          0, 0,            0,            0, 0,    9'b000000000, 16,           0,  1,  2,  0,  0);
      issue("bge_t",    32'h0020D863, 100,  1,           32'hFFFFFFFF, 0, 0,           0,            1, 116,  9'b000000000, 16,           0,  1,  2,  0,  0);
      issue("bge_eq",   32'h0020D863, 100,  5,           5,           0, 0,            0,            1, 116,  9'b000000000, 16,           0,  1,  2,  0,  0);
      issue("br_bad",   32'h0020A863, 100,  5,           5,           0, 0,            0,            0, 0,    9'b000000000, 16,           0,  1,  2,  0,  0);
      issue("jal",      32'hFF9FF0EF, 200,  0,           0,           0, 0,            0,            1, 192,  9'b110000000, 32'hFFFFFFF8, 1,  31, 25, 0,  0);
      issue("jalr",     32'h004182E7, 300,  1001,        0,           0, 0,            0,            1, 1004, 9'b110000000, 4,            5,  3,  4,  0,  0);
      issue("sd",       32'hFE613E23, 500,  100,         77,          0, 0,            0,            0, 0,    9'b000010001, 32'hFFFFFFFC, 0,  2,  6,  0,  0);
      issue("ld",       32'hFFC43383, 504,  200,         9,           0, 0,            0,            0, 0,    9'b101100001, 32'hFFFFFFFC, 7,  8,  28, 0,  0);
      issue("add",      32'h005201B3, 508,  3,           4,           0, 0,            0,            0, 0,    9'b100000000, 0,            3,  4,  5,  0,  0);
      issue("sub",      32'h405201B3, 512,  3,           4,           0, 0,            0,            0, 0,    9'b100000010, 0,            3,  4,  5,  0,  0);
      issue("and",      32'h005271B3, 516,  3,           4,           0, 0,            0,            0, 0,    9'b100000100, 0,            3,  4,  5,  0,  0);
      issue("or",       32'h005261B3, 520,  3,           4,           0, 0,            0,            0, 0,    9'b100000110, 0,            3,  4,  5,  0,  0);
      issue("sll",      32'h005211B3, 524,  3,           4,           0, 0,            0,            0, 0,    9'b100001000, 0,            3,  4,  5,  0,  0);
      issue("slt",      32'h005221B3, 528,  3,           4,           0, 0,            0,            0, 0,    9'b100001010, 0,            3,  4,  5,  0,  0);
      issue("bad_f7",   32'h405271B3, 532,  3,           4,           0, 0,            0,            0, 0,    9'b000000000, 0,            0,  4,  5,  0,  0);
      issue("unknown",  32'h0000007F, 536,  0,           0,           0, 0,            0,            0, 0,    9'b000000000, 0,            0,  0,  0,  0,  0);
      issue("nop",      32'h00000000, 540,  0,           0,           0, 0,            0,            0, 0,    9'b000000000, 0,            0,  0,  0,  0,  0);
      drain();

      // Load a JAL outside the scoreboard, then assert reset between edges.
      @(posedge clk);
      #1;
      pipe_data = 32'hFF9FF0EF; pipe_pc = 200; pipe_pc4 = 204;
      load_pc_reg_value1 = 32'd55; load_pc_reg_value2 = 32'd66;
      @(posedge clk);
      #2;
      check("pre_rst.ctrl_ex", {23'b0, ctrl_ex}, {23'b0, 9'b110000000});
      reset_n = 1'b0;
      #1;
      check("mid_rst.ctrl_ex",   {23'b0, ctrl_ex}, 32'd0);
      check("mid_rst.pc4_ex",    pc4_ex,   32'd0);
      check("mid_rst.r_data1",   r_data1,  32'd0);
      check("mid_rst.r_data2",   r_data2,  32'd0);
      check("mid_rst.extended",  extended, 32'd0);
      check("mid_rst.rd_ex",     rd_ex,    32'd0);
      check("mid_rst.control_j", {31'b0, control_j}, 32'd0);
      check("mid_rst.pc_j",      pc_j,     32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      issue("post_rst", 32'h007A0613, 400,  8,           33,          1, 12,           15,           0, 0,    9'b100000001, 7,            12, 20, 7,  12, 15);
      issue("post_unk", 32'h0000007F, 404,  1,           2,           0, 12,           15,           0, 0,    9'b000000000, 0,            0,  0,  0,  0,  0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
